// File: rtl/ascon_round_ctrl.sv
// ascon_round_ctrl: round sequencer for an ASCON permutation datapath.
// Drives the 320-bit state register (load mux select, write enable) and the
// round-constant index. p^a runs ROUNDS_A rounds and p^b runs ROUNDS_B rounds.
// Both always finish on round index 11, so the start index is 12 - rounds.
// Both round counts must lie in 1..12.
//
// Optional feature: define ASCON_PERM_ABORT_EN to add abort_i. While a
// permutation is loading or running, abort_i returns the controller to IDLE
// on the next edge, with no done_o pulse. abort_i takes priority over
// start_i. It is ignored in IDLE and DONE.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i; ready_o=1
// LOAD  | one cycle; state register takes the external state
// RUN   | one round per cycle; round_o counts up to 11
// DONE  | one-cycle done_o pulse; ready_o=1, start_i goes straight to LOAD

module ascon_round_ctrl #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 8
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       mode_i,
`ifdef ASCON_PERM_ABORT_EN
    input  logic       abort_i,
`endif
    output logic [3:0] round_o,
    output logic       sel_load_o,
    output logic       state_en_o,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] PRESET_A   = 4'(12 - ROUNDS_A);
    localparam logic [3:0] PRESET_B   = 4'(12 - ROUNDS_B);
    localparam logic [3:0] LAST_ROUND = 4'd11;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [3:0] round_q;
    logic [3:0] round_d;
    logic       abort_w;
    logic [3:0] preset_w;

`ifdef ASCON_PERM_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // Start index for the round that is about to be accepted.
    assign preset_w = mode_i ? PRESET_B : PRESET_A;

    // Next-state and round-index logic. The round index is captured on the
    // accept edge, so mode_i has no effect once a permutation has begun.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    round_d = preset_w;
                end
            end
            S_LOAD: begin
                if (abort_w) begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_w) begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                end else if (round_q == LAST_ROUND) begin
                    // The index is held at 11 here rather than wrapped.
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    round_d = preset_w;
                end else begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    // State and round registers. Reset is asynchronous and returns to IDLE.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // Outputs are decoded from registered state only, so they follow reset
    // immediately and have no combinational path from the inputs.
    assign round_o    = round_q;
    assign sel_load_o = (state_q == S_LOAD);
    assign state_en_o = (state_q == S_LOAD) || (state_q == S_RUN);
    assign busy_o     = (state_q == S_LOAD) || (state_q == S_RUN);
    assign ready_o    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Testbench for ascon_round_ctrl. Every accepted start pushes its expected
// LOAD cycle, its RUN cycles with round indices, and its done cycle. A
// negedge monitor pops these entries and compares them as the DUT produces them.
module tb_ascon_round_ctrl;

    logic       clock_i;
    logic       reset_i;
    logic       start_i;
    logic       mode_i;
`ifdef ASCON_PERM_ABORT_EN
    logic       abort_i;
`endif
    logic [3:0] round_o;
    logic       sel_load_o;
    logic       state_en_o;
    logic       ready_o;
    logic       busy_o;
    logic       done_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int en_cnt = 0;
    int t;

    int q_load_cyc[$];
    int q_load_rnd[$];
    int q_run_cyc[$];
    int q_run_rnd[$];
    int q_done_cyc[$];

    ascon_round_ctrl #(.ROUNDS_A(12), .ROUNDS_B(8)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .mode_i     (mode_i),
`ifdef ASCON_PERM_ABORT_EN
        .abort_i    (abort_i),
`endif
        .round_o    (round_o),
        .sel_load_o (sel_load_o),
        .state_en_o (state_en_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    always @(posedge clock_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected trace for a start accepted in cycle ts.
    task automatic push_perm(input int ts, input bit m);
        int n;
        int pre;
        n   = m ? 8 : 12;
        pre = 12 - n;
        q_load_cyc.push_back(ts + 1);
        q_load_rnd.push_back(pre);
        for (int i = 0; i < n; i++) begin
            q_run_cyc.push_back(ts + 2 + i);
            q_run_rnd.push_back(pre + i);
        end
        q_done_cyc.push_back(ts + 2 + n);
    endtask

    task automatic flush_q();
        q_load_cyc.delete();
        q_load_rnd.delete();
        q_run_cyc.delete();
        q_run_rnd.delete();
        q_done_cyc.delete();
    endtask

    task automatic step();
        @(negedge clock_i);
    endtask

    // Monitor: pop expected entries as LOAD, RUN and DONE cycles appear.
    always @(negedge clock_i) begin
        if (state_en_o === 1'b1) en_cnt++;
        if (sel_load_o === 1'b1) begin
            chk("load_en", state_en_o, 1);
            if (q_load_cyc.size() == 0) chk("load_unexp", 1, 0);
            else begin
                chk("load_cyc", cyc, q_load_cyc.pop_front());
                chk("load_rnd", round_o, q_load_rnd.pop_front());
            end
        end else if (state_en_o === 1'b1) begin
            chk("run_busy", busy_o, 1);
            chk("run_ready", ready_o, 0);
            if (q_run_cyc.size() == 0) chk("run_unexp", 1, 0);
            else begin
                chk("run_cyc", cyc, q_run_cyc.pop_front());
                chk("run_rnd", round_o, q_run_rnd.pop_front());
            end
        end else begin
            chk("idle_ready", ready_o, 1);
        end
        if (done_o === 1'b1) begin
            chk("done_en", state_en_o, 0);
            if (q_done_cyc.size() == 0) chk("done_unexp", 1, 0);
            else chk("done_cyc", cyc, q_done_cyc.pop_front());
        end
    end

    initial begin
        reset_i = 1'b1;
        start_i = 1'b0;
        mode_i  = 1'b0;
`ifdef ASCON_PERM_ABORT_EN
        abort_i = 1'b0;
`endif
        #7;
        chk("rst_round", round_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_en", state_en_o, 0);
        chk("rst_sel", sel_load_o, 0);
        step(); step();
        reset_i = 1'b0;
        step();

        // Single p^a, then a single p^b.
        for (int m = 0; m < 2; m++) begin
            t = cyc;
            en_cnt = 0;
            start_i = 1'b1;
            mode_i  = m[0];
            push_perm(t, m[0]);
            step();
            start_i = 1'b0;
            mode_i  = ~m[0];
            chk("load_ready", ready_o, 0);
            repeat (14) step();
            chk("en_count", en_cnt, (m == 0) ? 13 : 9);
            chk("end_ready", ready_o, 1);
        end

        // Back-to-back p^b with start held high: three permutations 10 cycles apart.
        step();
        t = cyc;
        start_i = 1'b1;
        mode_i  = 1'b1;
        push_perm(t, 1'b1);
        push_perm(t + 10, 1'b1);
        push_perm(t + 20, 1'b1);
        while (cyc < t + 21) step();
        start_i = 1'b0;
        repeat (12) step();

        // start held and mode toggled during RUN: no restart, no timing change.
        t = cyc;
        start_i = 1'b1;
        mode_i  = 1'b0;
        push_perm(t, 1'b0);
        step();
        while (cyc < t + 14) begin
            mode_i = ~mode_i;
            step();
        end
        start_i = 1'b0;
        mode_i  = 1'b0;
        repeat (3) step();

        // Asynchronous reset in the middle of RUN (round 5).
        t = cyc;
        start_i = 1'b1;
        push_perm(t, 1'b0);
        step();
        start_i = 1'b0;
        while (cyc < t + 7) step();
        chk("pre_rst_round", round_o, 5);
        #2 reset_i = 1'b1;
        #1;
        chk("mid_rst_round", round_o, 0);
        chk("mid_rst_en", state_en_o, 0);
        chk("mid_rst_ready", ready_o, 1);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_sel", sel_load_o, 0);
        chk("mid_rst_done", done_o, 0);
        flush_q();
        step(); step();
        reset_i = 1'b0;
        repeat (20) step();
        t = cyc;
        start_i = 1'b1;
        push_perm(t, 1'b0);
        step();
        start_i = 1'b0;
        repeat (15) step();

`ifdef ASCON_PERM_ABORT_EN
        // Abort at round 7, together with start to check that abort wins.
        t = cyc;
        start_i = 1'b1;
        push_perm(t, 1'b0);
        step();
        start_i = 1'b0;
        while (cyc < t + 9) step();
        chk("pre_abort_round", round_o, 7);
        abort_i = 1'b1;
        start_i = 1'b1;
        step();
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("abort_ready", ready_o, 1);
        chk("abort_round", round_o, 0);
        chk("abort_en", state_en_o, 0);
        chk("abort_done", done_o, 0);
        flush_q();
        repeat (5) step();
        // abort_i held in IDLE must not block the next start.
        t = cyc;
        start_i = 1'b1;
        abort_i = 1'b1;
        push_perm(t, 1'b0);
        step();
        start_i = 1'b0;
        abort_i = 1'b0;
        repeat (15) step();
`endif

        chk("left_load", q_load_cyc.size(), 0);
        chk("left_run", q_run_cyc.size(), 0);
        chk("left_done", q_done_cyc.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascon_round_ctrl.md
ASCON_ROUND_CTRL -- requirements
Module: ascon_round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS_A, default 12, number of rounds for p^a (full permutation).
REQ-002 SHALL have parameter ROUNDS_B, default 8, number of rounds for p^b (ASCON-AEAD128a data permutation).
REQ-003 SHALL have port clock_i  input  1  rising-edge clock.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  permutation request; accepted only while ready_o=1.
REQ-006 SHALL have port mode_i  input  1  0 = ROUNDS_A rounds, 1 = ROUNDS_B rounds; sampled on the accept cycle.
REQ-007 SHALL have port round_o  output  4  round index for the constant-addition stage (0..11).
REQ-008 SHALL have port sel_load_o  output  1  1 = state register mux takes the external state, 0 = takes the round-function output.
REQ-009 SHALL have port state_en_o  output  1  320-bit state register write enable.
REQ-010 SHALL have port ready_o  output  1  controller can accept start_i.
REQ-011 SHALL have port busy_o  output  1  rounds in progress.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse; state register holds the permuted state.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-014 SHALL move IDLE->LOAD when start_i=1; otherwise stay in IDLE.
REQ-015 LOAD SHALL last exactly one cycle, with sel_load_o=1 and state_en_o=1; round_o SHALL be preset to 12-ROUNDS_A (mode_i=0) or 12-ROUNDS_B (mode_i=1), captured from the accept-cycle mode_i.
REQ-016 RUN SHALL assert state_en_o=1, sel_load_o=0 and busy_o=1 every cycle, and increment round_o by 1 per cycle.
REQ-017 SHALL move RUN->DONE in the cycle round_o=11; round_o SHALL never exceed 11 or wrap.
REQ-018 Latency: for an accept at cycle t, LOAD occurs at t+1, RUN at t+2..t+1+N (N = selected round count), and done_o=1 at t+2+N.
REQ-019 DONE SHALL last one cycle, with done_o=1, ready_o=1 and state_en_o=0.
REQ-020 start_i=1 in DONE SHALL go directly to LOAD (back-to-back, no IDLE cycle); otherwise DONE SHALL go to IDLE.
REQ-021 ready_o SHALL be 1 only in IDLE and DONE; start_i in LOAD or RUN SHALL be ignored, not queued.
REQ-022 mode_i changes after the accept cycle SHALL have no effect on the running permutation.
REQ-023 state_en_o SHALL be 0 in IDLE and DONE.
REQ-024 All outputs SHALL be registered or decoded only from FSM state and the round register, with no combinational path from inputs.

Reset
REQ-025 reset_i=1 SHALL asynchronously force IDLE, round_o=0, sel_load_o=0, state_en_o=0, busy_o=0, done_o=0 and ready_o=1.
REQ-026 Reset during LOAD or RUN SHALL abandon the permutation without a done_o pulse; the first start_i after reset release SHALL behave as from power-up.

Configuration
REQ-027 Macro ASCON_PERM_ABORT_EN defined: SHALL add an input port abort_i (1 bit); abort_i=1 in LOAD or RUN SHALL go to IDLE on the next edge, with no done_o, state_en_o=0 and round_o=0.
REQ-028 abort_i SHALL have priority over start_i and be ignored in IDLE and DONE.
REQ-029 Macro ASCON_PERM_ABORT_EN undefined: SHALL have no abort_i port; behaviour SHALL be otherwise identical.

Verification
REQ-030 mode_i=0, start_i pulse at cycle 0 -> LOAD at cycle 1; round_o=0..11 at cycles 2..13 with state_en_o=1; done_o=1 at cycle 14 only.
REQ-031 mode_i=1, start_i at cycle 0 -> round_o=4..11 at cycles 2..9; done_o at cycle 10; exactly 9 state_en_o cycles in total.
REQ-032 start_i held high continuously, mode_i=1 -> DONE->LOAD with no IDLE cycle; done_o pulses every 10 cycles.
REQ-033 start_i=1 and mode_i toggled during RUN -> no restart; round sequence and done timing are unchanged.
REQ-034 reset_i asserted while round_o=5 -> outputs take reset values immediately (before the next edge); no done_o is produced.
REQ-035 With ASCON_PERM_ABORT_EN defined, abort_i=1 while round_o=7 -> IDLE next cycle, ready_o=1, no done_o; a new start then runs all rounds from 0.
